// File: rtl/emu_host_pkg.sv
// Shared state encoding, default widths and helpers for the emulator host sequencer.
package emu_host_pkg;

    localparam int DEF_INSN_W = 64;
    localparam int DEF_IO_W   = 32;
    localparam int DEF_CNT_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN_IN,
        ST_RUN_CYC,
        ST_RUN_OUT,
        ST_WAIT_ACK,
        ST_DONE
    } seq_state_e;

    // A step always spends at least one cycle computing, even when zero procs are requested.
    function automatic logic [7:0] cycle_load(input logic [7:0] procs);
        return (procs == 8'd0) ? 8'd1 : procs;
    endfunction

endpackage

// File: rtl/host_slot.sv
// Host request slot: rising-edge detector on a wire-in level plus a one-entry
// holding register presented to the emulator as a valid/ready source.
module host_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              lvl,
    input  logic [DATA_W-1:0] bits,
    input  logic              accept,
    input  logic              active,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              slot_free,
    output logic              drop
);

    logic lvl_prev;
    logic armed;
    logic full;
    logic edge_evt;
    logic fire;

    // armed stays low for the first cycle after reset so a level already high is not an event
    assign edge_evt  = armed & lvl & ~lvl_prev;
    assign valid     = full & active;
    assign fire      = valid & ready;
    assign slot_free = ~full;
    assign drop      = edge_evt & (full | ~accept);

    // Remember last level to find rising edges
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lvl_prev <= 1'b0;
            armed    <= 1'b0;
        end else begin
            lvl_prev <= lvl;
            armed    <= 1'b1;
        end
    end

    // Capture payload into an empty slot; release it after the handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (edge_evt && accept && !full) begin
            full <= 1'b1;
            data <= bits;
        end else if (fire) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/emu_host_sequencer.sv
// Host-side sequencer: feeds instructions and per-step input tokens to the
// emulator, times the compute cycles, and hands each output back to the host.
module emu_host_sequencer
    import emu_host_pkg::*;
#(
    parameter int INSN_W = DEF_INSN_W,
    parameter int IO_W   = DEF_IO_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CNT_W-1:0]  host_steps_i,
    input  logic [7:0]        used_procs_i,
    input  logic              start_i,
    input  logic              insn_lvl_i,
    input  logic [INSN_W-1:0] insn_bits_i,
    input  logic              in_lvl_i,
    input  logic [IO_W-1:0]   in_bits_i,
    input  logic              out_ack_lvl_i,
    output logic              insn_valid_o,
    output logic [INSN_W-1:0] insn_bits_o,
    input  logic              insn_ready_i,
    output logic              in_valid_o,
    output logic [IO_W-1:0]   in_bits_o,
    input  logic              in_ready_i,
    input  logic              emu_out_valid_i,
    input  logic [IO_W-1:0]   emu_out_bits_i,
    output logic              emu_out_ready_o,
    output logic              insn_slot_free_o,
    output logic              in_slot_free_o,
    output logic              out_valid_o,
    output logic [IO_W-1:0]   out_bits_o,
    output logic [CNT_W-1:0]  steps_done_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    seq_state_e       state;
    seq_state_e       state_next;
    logic             start_prev;
    logic             ack_prev;
    logic             armed;
    logic             start_evt;
    logic             ack_evt;
    logic             run_start;
    logic             load_cyc;
    logic             capture_out;
    logic             ack_step;
    logic             insn_drop;
    logic             in_drop;
    logic [7:0]       cyc_cnt;
    logic [CNT_W-1:0] steps_total;
    logic [CNT_W-1:0] steps_inc;
    logic             in_idle;
    logic             in_run_in;

    assign start_evt = armed & start_i & ~start_prev;
    assign ack_evt   = armed & out_ack_lvl_i & ~ack_prev;
    assign steps_inc = steps_done_o + CNT_W'(1);
    assign in_idle   = (state == ST_IDLE);
    assign in_run_in = (state == ST_RUN_IN);

    // Instructions are only taken and offered while idle
    host_slot #(.DATA_W(INSN_W)) u_insn_slot (
        .clock     (clock),
        .reset_n   (reset_n),
        .lvl       (insn_lvl_i),
        .bits      (insn_bits_i),
        .accept    (in_idle),
        .active    (in_idle),
        .ready     (insn_ready_i),
        .valid     (insn_valid_o),
        .data      (insn_bits_o),
        .slot_free (insn_slot_free_o),
        .drop      (insn_drop)
    );

    // Inputs may be queued in any state but are only offered in RUN_IN
    host_slot #(.DATA_W(IO_W)) u_in_slot (
        .clock     (clock),
        .reset_n   (reset_n),
        .lvl       (in_lvl_i),
        .bits      (in_bits_i),
        .accept    (1'b1),
        .active    (in_run_in),
        .ready     (in_ready_i),
        .valid     (in_valid_o),
        .data      (in_bits_o),
        .slot_free (in_slot_free_o),
        .drop      (in_drop)
    );

    // Edge history for start and output-ack levels
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_prev <= 1'b0;
            ack_prev   <= 1'b0;
            armed      <= 1'b0;
        end else begin
            start_prev <= start_i;
            ack_prev   <= out_ack_lvl_i;
            armed      <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, datapath strobes and status outputs
    always_comb begin
        state_next      = state;
        run_start       = 1'b0;
        load_cyc        = 1'b0;
        capture_out     = 1'b0;
        ack_step        = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;
        emu_out_ready_o = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_evt) begin
                    run_start  = 1'b1;
                    state_next = (host_steps_i == '0) ? ST_DONE : ST_RUN_IN;
                end
            end
            ST_RUN_IN: begin
                if (in_valid_o && in_ready_i) begin
                    load_cyc   = 1'b1;
                    state_next = ST_RUN_CYC;
                end
            end
            ST_RUN_CYC: begin
                if (cyc_cnt <= 8'd1) begin
                    state_next = ST_RUN_OUT;
                end
            end
            ST_RUN_OUT: begin
                emu_out_ready_o = 1'b1;
                if (emu_out_valid_i) begin
                    capture_out = 1'b1;
                    state_next  = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_evt) begin
                    ack_step   = 1'b1;
                    state_next = (steps_inc >= steps_total) ? ST_DONE : ST_RUN_IN;
                end
            end
            ST_DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
                if (!start_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Step/cycle counters, host output register and sticky error
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            steps_total  <= '0;
            steps_done_o <= '0;
            cyc_cnt      <= 8'd0;
            out_valid_o  <= 1'b0;
            out_bits_o   <= '0;
            err_o        <= 1'b0;
        end else begin
            if (run_start) begin
                steps_total  <= host_steps_i;
                steps_done_o <= '0;
            end else if (ack_step) begin
                steps_done_o <= steps_inc;
            end
            if (load_cyc) begin
                cyc_cnt <= cycle_load(used_procs_i);
            end else if (state == ST_RUN_CYC) begin
                cyc_cnt <= cyc_cnt - 8'd1;
            end
            if (capture_out) begin
                out_valid_o <= 1'b1;
                out_bits_o  <= emu_out_bits_i;
            end else if (ack_step) begin
                out_valid_o <= 1'b0;
            end
            err_o <= (err_o & ~run_start) | insn_drop | in_drop;
        end
    end

endmodule
